// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command issuer and its command FIFO.
package alu_pkg;

    localparam int unsigned ALU_OP_W  = 2;
    localparam int unsigned ALU_IN_W  = 8;
    localparam int unsigned ALU_OUT_W = 16;

    localparam logic [ALU_OUT_W-1:0] ALU_DIV0_RESULT = 16'hFFFF;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_MUL = 2'd2,
        ALU_DIV = 2'd3
    } alu_op_e;

    typedef struct packed {
        alu_op_e               sel;
        logic [ALU_IN_W-1:0]   num1;
        logic [ALU_IN_W-1:0]   num2;
    } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// DEPTH-entry command FIFO; full/empty come from one extra pointer bit.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  alu_cmd_t din,
    input  logic     pop,
    output alu_cmd_t dout,
    output logic     full,
    output logic     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0] wr_q;
    logic [AW:0] rd_q;
    alu_cmd_t    mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) begin
                mem[wr_q[AW-1:0]] <= din;
                wr_q              <= wr_q + PTR_ONE;
            end
            if (pop) begin
                rd_q <= rd_q + PTR_ONE;
            end
        end
    end

    assign dout  = mem[rd_q[AW-1:0]];
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/alu_cmd_issuer.sv
// Queues ALU commands, holds operands for a settle window, then returns the captured result.
// Optional macro ALU_DIV_ZERO_CHECK_EN: divide-by-zero commands bypass the ALU and report an error.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ALU_OP_W-1:0]  cmd_sel,
    input  logic [ALU_IN_W-1:0]  cmd_num1,
    input  logic [ALU_IN_W-1:0]  cmd_num2,
    output logic [ALU_IN_W-1:0]  alu_num1,
    output logic [ALU_IN_W-1:0]  alu_num2,
    output logic [ALU_OP_W-1:0]  alu_sel,
    output logic                 alu_reset,
    input  logic [ALU_OUT_W-1:0] alu_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ALU_OUT_W-1:0] rsp_result,
    output logic [ALU_OP_W-1:0]  rsp_sel,
    output logic                 rsp_err,
    output logic                 busy
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pop;
    logic             capture;
    logic             rsp_clear;
    logic             alu_reset_d;
    logic             div0_q;
    logic             head_div0;
    logic             alive_q;
    logic             push;
    logic             full;
    logic             empty;
    alu_cmd_t         push_cmd;
    alu_cmd_t         head;

    // alive_q keeps cmd_ready low until the first cycle after reset releases
    assign cmd_ready = alive_q && !full;
    assign push      = cmd_valid && cmd_ready;
    assign push_cmd  = '{sel: alu_op_e'(cmd_sel), num1: cmd_num1, num2: cmd_num2};
    assign busy      = (state_q != IDLE) || !empty;

`ifdef ALU_DIV_ZERO_CHECK_EN
    assign head_div0 = (head.sel == ALU_DIV) && (head.num2 == '0);
`else
    assign head_div0 = 1'b0;
`endif

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (push_cmd),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // Next-state and control decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pop         = 1'b0;
        capture     = 1'b0;
        rsp_clear   = 1'b0;
        alu_reset_d = alu_reset;
        case (state_q)
            IDLE: begin
                alu_reset_d = 1'b1;
                if (!empty) begin
                    pop         = 1'b1;
                    cnt_d       = CNT_LOAD;
                    state_d     = SETTLE;
                    alu_reset_d = head_div0;
                end
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = CNT_W'(cnt_q - 1'b1);
                end else begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_clear = 1'b1;
                    if (!empty) begin
                        pop         = 1'b1;
                        cnt_d       = CNT_LOAD;
                        state_d     = SETTLE;
                        alu_reset_d = head_div0;
                    end else begin
                        state_d     = IDLE;
                        alu_reset_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                alu_reset_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            alive_q    <= 1'b0;
            alu_num1   <= '0;
            alu_num2   <= '0;
            alu_sel    <= '0;
            alu_reset  <= 1'b1;
            div0_q     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_sel    <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            alive_q   <= 1'b1;
            alu_reset <= alu_reset_d;
            if (pop) begin
                alu_num1 <= head.num1;
                alu_num2 <= head.num2;
                alu_sel  <= head.sel;
                div0_q   <= head_div0;
            end
            // A suppressed divide reports the fixed error code instead of the ALU output
            if (capture) begin
                rsp_valid  <= 1'b1;
                rsp_result <= div0_q ? ALU_DIV0_RESULT : alu_result;
                rsp_sel    <= alu_sel;
                rsp_err    <= div0_q;
            end else if (rsp_clear) begin
                rsp_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer with a behavioural ALU and a reference result model.
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned SETTLE = 2;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_sel;
    logic [7:0]  cmd_num1;
    logic [7:0]  cmd_num2;
    logic [7:0]  alu_num1;
    logic [7:0]  alu_num2;
    logic [1:0]  alu_sel;
    logic        alu_reset;
    logic [15:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [1:0]  rsp_sel;
    logic        rsp_err;
    logic        busy;

    alu_cmd_issuer #(.DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_sel(cmd_sel), .cmd_num1(cmd_num1), .cmd_num2(cmd_num2),
        .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_sel(alu_sel), .alu_reset(alu_reset),
        .alu_result(alu_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_sel(rsp_sel), .rsp_err(rsp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational ALU stand-in; divide by zero yields a recognisable marker
    always_comb begin
        alu_result = 16'h0000;
        if (!alu_reset) begin
            case (alu_sel)
                2'd0:    alu_result = 16'(alu_num1) + 16'(alu_num2);
                2'd1:    alu_result = 16'(alu_num1) - 16'(alu_num2);
                2'd2:    alu_result = 16'(alu_num1) * 16'(alu_num2);
                default: alu_result = (alu_num2 == 8'd0) ? 16'hBEEF : 16'(alu_num1 / alu_num2);
            endcase
        end
    end

    typedef struct {
        logic [15:0] res;
        logic [1:0]  sel;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   t_acc    = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endfunction

    function automatic exp_t model(logic [1:0] sel, logic [7:0] a, logic [7:0] b);
        exp_t e;
        int   r;
        e.sel = sel;
        e.err = 1'b0;
        case (sel)
            2'd0: r = int'(a) + int'(b);
            2'd1: r = int'(a) - int'(b);
            2'd2: r = int'(a) * int'(b);
            default: begin
                if (b == 8'd0) begin
`ifdef ALU_DIV_ZERO_CHECK_EN
                    r     = 32'h0000FFFF;
                    e.err = 1'b1;
`else
                    r     = 32'h0000BEEF;
`endif
                end else begin
                    r = int'(a) / int'(b);
                end
            end
        endcase
        e.res = r[15:0];
        return e;
    endfunction

    // Monitor: pops on every response handshake and checks stability while stalled
    logic        stall_prev = 1'b0;
    logic [15:0] prev_res;
    logic [1:0]  prev_sel;
    logic        prev_err;
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid_held", 32'(rsp_valid), 32'd1);
                chk("stall_result_held", 32'(rsp_result), 32'(prev_res));
                chk("stall_sel_held", 32'(rsp_sel), 32'(prev_sel));
                chk("stall_err_held", 32'(rsp_err), 32'(prev_err));
            end
            if (rsp_valid && rsp_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_response", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("rsp_result", 32'(rsp_result), 32'(e.res));
                    chk("rsp_sel", 32'(rsp_sel), 32'(e.sel));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
            stall_prev = rsp_valid && !rsp_ready;
            prev_res   = rsp_result;
            prev_sel   = rsp_sel;
            prev_err   = rsp_err;
        end
    end

    task automatic send(input logic [1:0] sel, input logic [7:0] a, input logic [7:0] b,
                        input bit use_exp, input logic [15:0] req_res, input logic req_err);
        exp_t e;
        bit   ok;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_sel   = sel;
        cmd_num1  = a;
        cmd_num2  = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("cmd_accept_timeout", 32'd0, 32'd1);
        end else begin
            e = model(sel, a, b);
            if (use_exp) begin
                e.res = req_res;
                e.err = req_err;
            end
            sbq.push_back(e);
            t_acc = cyc;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic directed(input logic [1:0] sel, input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] req_res, input logic req_err, input bit rst_hold);
        int lat;
        lat       = -1;
        rsp_ready = 1'b1;
        send(sel, a, b, 1'b1, req_res, req_err);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rst_hold) chk("div0_alu_reset_high", 32'(alu_reset), 32'd1);
            if (rsp_valid) begin
                lat = cyc - t_acc;
                break;
            end
        end
        chk("latency", 32'(lat), 32'(2 + SETTLE));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (sbq.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_queue_empty", 32'(sbq.size()), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("idle_not_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    bit done = 1'b0;

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_sel   = 2'd0;
        cmd_num1  = 8'd0;
        cmd_num2  = 8'd0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_result", 32'(rsp_result), 32'd0);
        chk("rst_rsp_sel", 32'(rsp_sel), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_alu_ops", {16'(alu_num1), 8'(alu_num2), 6'(alu_sel)}, 32'd0);
        chk("rst_alu_reset", 32'(alu_reset), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed arithmetic with latency
        directed(2'd0, 8'd5, 8'd3, 16'h0008, 1'b0, 1'b0);
        directed(2'd1, 8'd3, 8'd5, 16'hFFFE, 1'b0, 1'b0);
        directed(2'd2, 8'd12, 8'd13, 16'h009C, 1'b0, 1'b0);
        directed(2'd3, 8'd20, 8'd4, 16'h0005, 1'b0, 1'b0);
`ifdef ALU_DIV_ZERO_CHECK_EN
        directed(2'd3, 8'd7, 8'd0, 16'hFFFF, 1'b1, 1'b1);
`else
        directed(2'd3, 8'd7, 8'd0, 16'hBEEF, 1'b0, 1'b0);
`endif
        drain();

        // Fill with consumer stalled: DEPTH queued plus one in flight
        begin
            int acc;
            acc       = 0;
            rsp_ready = 1'b0;
            cmd_valid = 1'b1;
            cmd_sel   = 2'($urandom_range(0, 3));
            cmd_num1  = 8'($urandom);
            cmd_num2  = 8'($urandom_range(1, 255));
            for (int i = 0; i < 14; i++) begin
                @(negedge clk);
                if (cmd_ready) begin
                    acc++;
                    sbq.push_back(model(cmd_sel, cmd_num1, cmd_num2));
                    @(posedge clk);
                    #1;
                    cmd_sel  = 2'($urandom_range(0, 3));
                    cmd_num1 = 8'($urandom);
                    cmd_num2 = 8'($urandom_range(1, 255));
                end else begin
                    @(posedge clk);
                    #1;
                end
            end
            chk("fill_accept_count", 32'(acc), 32'(DEPTH + 1));
            @(negedge clk);
            chk("fill_cmd_ready_low", 32'(cmd_ready), 32'd0);
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            rsp_ready = 1'b1;
            drain();
        end

        // Back-to-back spacing with consumer always ready
        begin
            int times[$];
            int rst_hi;
            rst_hi    = 0;
            rsp_ready = 1'b1;
            fork
                begin
                    for (int i = 0; i < 4; i++)
                        send(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom_range(1, 255)),
                             1'b0, 16'h0, 1'b0);
                end
                begin
                    for (int i = 0; i < 80 && times.size() < 4; i++) begin
                        @(negedge clk);
                        if (times.size() > 0 && alu_reset) rst_hi++;
                        if (rsp_valid) times.push_back(cyc);
                    end
                end
            join
            chk("b2b_response_count", 32'(times.size()), 32'd4);
            for (int i = 1; i < times.size(); i++)
                chk("b2b_spacing", 32'(times[i] - times[i-1]), 32'(SETTLE + 1));
            chk("b2b_alu_reset_no_pulse", 32'(rst_hi), 32'd0);
            drain();
        end

        // Reset during SETTLE with two commands queued
        begin
            int seen;
            seen      = 0;
            rsp_ready = 1'b1;
            for (int i = 0; i < 3; i++)
                send(2'd0, 8'(i + 1), 8'd1, 1'b0, 16'h0, 1'b0);
            @(negedge clk);
            chk("pre_reset_settle", {30'd0, rsp_valid, alu_reset}, 32'd0);
            reset = 1'b1;
            sbq.delete();
            @(posedge clk);
            @(negedge clk);
            chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("midrst_busy", 32'(busy), 32'd0);
            chk("midrst_alu_reset", 32'(alu_reset), 32'd1);
            @(posedge clk);
            #1;
            reset = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (rsp_valid) seen++;
            end
            chk("no_rsp_after_reset", 32'(seen), 32'd0);
            @(posedge clk);
            #1;
            directed(2'd0, 8'd1, 8'd1, 16'h0002, 1'b0, 1'b0);
            drain();
        end

        // Randomized traffic with random consumer back-pressure
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [1:0] s;
                    logic [7:0] b;
                    s = 2'($urandom_range(0, 3));
                    b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
                    send(s, 8'($urandom), b, 1'b0, 16'h0, 1'b0);
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rsp_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
